// File: rtl/pc_sequencer_if.sv
// Bundles the fetch/multdiv signals of the program-counter sequencer.
// The slave modport belongs to the sequencer. The master modport belongs to
// whatever drives it, meaning the next-PC logic, the decoder and the multdiv
// unit.
interface pc_sequencer_if;
  logic [31:0] next_pc_in;
  logic        is_mult;
  logic        is_div;
  logic        md_ready;
  logic        md_exception;
  logic [31:0] pc;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic        stall;
  logic        md_wren;
  logic        md_error;
  logic        md_timeout;

  modport slave (
    input  next_pc_in, is_mult, is_div, md_ready, md_exception,
    output pc, ctrl_mult, ctrl_div, stall, md_wren, md_error, md_timeout
  );

  modport master (
    output next_pc_in, is_mult, is_div, md_ready, md_exception,
    input  pc, ctrl_mult, ctrl_div, stall, md_wren, md_error, md_timeout
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter register plus the sequencer for the iterative multdiv unit.
// A mult or div instruction pulses the unit's start line and then stalls in
// WAIT. The stall ends when the unit reports ready, which writes the result
// back. It also ends after MD_TIMEOUT cycles, which abandons the instruction.
// Constraints: 2 <= MD_TIMEOUT <= 63 and 2**CNT_W > MD_TIMEOUT.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          MD_TIMEOUT = 40,
  parameter int          CNT_W      = 6
) (
  input  logic          clock,
  input  logic          reset,   // asynchronous, active low
  pc_sequencer_if.slave bus
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      pc, pc_nxt;

  logic ctrl_mult_c, ctrl_div_c, stall_c, md_wren_c, md_error_c, md_timeout_c;

  // State, wait counter and PC registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
      cnt   <= '0;
      pc    <= RESET_PC;
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge values, so the order of these lines cannot matter.
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pc    <= pc_nxt;
    end
  end

  // Next-state, next-PC and pulse decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_nxt       = pc;
    ctrl_mult_c  = 1'b0;
    ctrl_div_c   = 1'b0;
    stall_c      = 1'b0;
    md_wren_c    = 1'b0;
    md_error_c   = 1'b0;
    md_timeout_c = 1'b0;

    unique case (state)
      ST_RUN: begin
        if (bus.is_mult || bus.is_div) begin
          // Mult wins if the decoder flags both.
          ctrl_mult_c = bus.is_mult;
          ctrl_div_c  = bus.is_div & ~bus.is_mult;
          stall_c     = 1'b1;
          state_nxt   = ST_WAIT;
          cnt_nxt     = '0;
        end else begin
          pc_nxt = bus.next_pc_in;
        end
      end

      ST_WAIT: begin
        if (bus.md_ready) begin
          // Ready beats a timeout that falls in the same cycle.
          md_wren_c  = 1'b1;
          md_error_c = bus.md_exception;
          pc_nxt     = bus.next_pc_in;
          state_nxt  = ST_RUN;
        end else if (cnt == CNT_LAST) begin
          // Give up on a hung unit and skip the instruction. Stall stays
          // high so the stale result is never written.
          md_timeout_c = 1'b1;
          stall_c      = 1'b1;
          pc_nxt       = bus.next_pc_in;
          state_nxt    = ST_RUN;
        end else begin
          stall_c = 1'b1;
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: state_nxt = ST_RUN;
    endcase
  end

  // Outputs go quiet while reset is held, even if the decoder flags an
  // instruction.
  assign bus.pc         = pc;
  assign bus.ctrl_mult  = reset & ctrl_mult_c;
  assign bus.ctrl_div   = reset & ctrl_div_c;
  assign bus.stall      = reset & stall_c;
  assign bus.md_wren    = reset & md_wren_c;
  assign bus.md_error   = reset & md_error_c;
  assign bus.md_timeout = reset & md_timeout_c;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer, built around a scoreboard.
// The driver works one instruction at a time. It picks a kind (plain, mult,
// div or both), the ready latency of the multdiv unit, the exception bit and
// the branch target. From those it derives the outputs expected in each
// cycle the instruction occupies and queues them.
// A separate monitor samples the DUT on every falling edge and compares the
// sample against the head of the queue.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC   = 32'd0;
  localparam int          MD_TIMEOUT = 40;
  localparam int          CNT_W      = 6;

  typedef struct packed {
    logic [31:0] pc;
    logic        cm;
    logic        cd;
    logic        stall;
    logic        wren;
    logic        err;
    logic        tmo;
  } obs_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC  (RESET_PC),
    .MD_TIMEOUT(MD_TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  obs_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_cycle  = 0;
  logic [31:0] m_pc     = RESET_PC;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got pc=%h cm=%b cd=%b st=%b wr=%b er=%b to=%b, expected pc=%h cm=%b cd=%b st=%b wr=%b er=%b to=%b",
                  name, act.pc, act.cm, act.cd, act.stall, act.wren, act.err, act.tmo,
                  exp.pc, exp.cm, exp.cd, exp.stall, exp.wren, exp.err, exp.tmo);
  endtask

  // Monitor: compare every falling-edge sample with the oldest expectation.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clock);
      n_cycle++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = '{bus.pc, bus.ctrl_mult, bus.ctrl_div, bus.stall,
              bus.md_wren, bus.md_error, bus.md_timeout};
        check($sformatf("cyc%0d", n_cycle), a, e);
      end
    end
  end

  // Drive one clock cycle of inputs (just after the rising edge) and queue
  // what the DUT should show during that cycle.
  task automatic step(input logic [31:0] npc, input bit im, input bit id,
                      input bit rdy, input bit exc, input bit rst_v,
                      input obs_t e);
    @(posedge clock);
    #1;
    reset            = rst_v;
    bus.next_pc_in   = npc;
    bus.is_mult      = im;
    bus.is_div       = id;
    bus.md_ready     = rdy;
    bus.md_exception = exc;
    exp_q.push_back(e);
  endtask

  function automatic obs_t idle_obs(input logic [31:0] p);
    return '{p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  endfunction

  // One instruction.
  //   kind: 0 plain, 1 mult, 2 div, 3 mult+div flagged together.
  //   lat:  the WAIT cycle (1..MD_TIMEOUT) in which ready rises; 0 means
  //         the unit never answers.
  //   rst_at: when non-zero, reset is pulled low in that WAIT cycle and the
  //         instruction is abandoned.
  task automatic do_instr(input int kind, input int lat, input bit exc,
                          input logic [31:0] target, input int rst_at = 0);
    obs_t e;
    if (kind == 0) begin
      e = idle_obs(m_pc);
      step(target, 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b1, e);
      m_pc = target;
      return;
    end
    // Issue cycle: one start pulse, with mult winning over div.
    e = idle_obs(m_pc);
    e.cm = (kind != 2);
    e.cd = (kind == 2);
    e.stall = 1'b1;
    step(target, kind != 2, kind != 1, 1'($urandom), 1'b0, 1'b1, e);
    for (int w = 1; w <= MD_TIMEOUT; w++) begin
      e = idle_obs(m_pc);
      if (w == rst_at) begin
        // Reset forces the registered PC back at once and kills all pulses.
        e = idle_obs(RESET_PC);
        step(target, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, e);
        m_pc = RESET_PC;
        return;
      end
      if (w == lat) begin
        e.wren = 1'b1;
        e.err  = exc;
        step(target, 1'($urandom), 1'($urandom), 1'b1, exc, 1'b1, e);
        break;
      end else if (w == MD_TIMEOUT) begin
        e.tmo   = 1'b1;
        e.stall = 1'b1;
        step(target, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, e);
        break;
      end else begin
        e.stall = 1'b1;
        step(target, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1, e);
      end
    end
    m_pc = target;
  endtask

  initial begin
    int kind, lat, r;
    logic [31:0] tgt;
    bus.next_pc_in   = 32'h0;
    bus.is_mult      = 1'b1;   // must not leak out while reset is held
    bus.is_div       = 1'b0;
    bus.md_ready     = 1'b0;
    bus.md_exception = 1'b0;

    // Reset held for two cycles.
    step(32'h1234, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, idle_obs(RESET_PC));
    step(32'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, idle_obs(RESET_PC));

    // Sequential fetch 0..5.
    for (int i = 0; i < 5; i++) do_instr(0, 0, 1'b0, m_pc + 1);
    do_instr(1, 4, 1'b0, m_pc + 1);   // mult at pc 5, ready in 4th WAIT cycle
    do_instr(2, 1, 1'b1, m_pc + 1);   // div, immediate ready with exception
    do_instr(3, 2, 1'b0, m_pc + 1);   // both flagged: mult wins
    do_instr(1, 0, 1'b0, m_pc + 1);   // hung unit: timeout, pc -> 9
    do_instr(1, 0, 1'b0, m_pc + 1, 3);  // reset in 3rd WAIT cycle at pc 9
    // Keep reset low for one more cycle with a mult flagged.
    step(32'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, idle_obs(RESET_PC));
    // Reset released. RUN resumes with no stray start pulse.
    do_instr(0, 0, 1'b0, m_pc + 1);
    do_instr(1, MD_TIMEOUT, 1'b1, m_pc + 1);  // ready coincides with timeout
    do_instr(1, 1, 1'b0, m_pc + 1);           // back-to-back mults
    do_instr(1, 3, 1'b1, m_pc + 1);

    // Randomized instruction stream.
    for (int i = 0; i < 150; i++) begin
      r    = int'($urandom_range(0, 9));
      kind = (r < 5) ? 0 : int'($urandom_range(1, 3));
      r    = int'($urandom_range(0, 9));
      lat  = (r < 6) ? int'($urandom_range(1, 6)) :
             (r < 8) ? int'($urandom_range(MD_TIMEOUT - 3, MD_TIMEOUT)) : 0;
      tgt  = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4;
      do_instr(kind, lat, 1'($urandom), tgt);
    end

    // Let the monitor consume the final expectation.
    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
